// File: rtl/mips_cpu_axi_lite_master.sv
// AXI4-Lite initiator for the MIPS core control port: one command in flight,
// converted to a single-beat AXI-Lite read or write with a registered response.
module mips_cpu_axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  mips_cpu_clk,
  input  logic                  mips_cpu_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_code,
  output logic                  resp_wr,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_d, resp_valid_d, resp_wr_d;
  logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_d, resp_rdata_d;
  logic [3:0]            wstrb_d;
  logic [1:0]            resp_code_d;
  logic                  aw_left, w_left;

  // One captured address serves both AW and AR; only one is ever valid.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  // Channels still owed a handshake after this edge.
  assign aw_left = m_axi_awvalid & ~m_axi_awready;
  assign w_left  = m_axi_wvalid & ~m_axi_wready;

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready;
    resp_valid_d = resp_valid;
    resp_wr_d    = resp_wr;
    resp_rdata_d = resp_rdata;
    resp_code_d  = resp_code;
    awvalid_d    = m_axi_awvalid;
    wvalid_d     = m_axi_wvalid;
    bready_d     = m_axi_bready;
    arvalid_d    = m_axi_arvalid;
    rready_d     = m_axi_rready;
    addr_d       = addr_q;
    wdata_d      = m_axi_wdata;
    wstrb_d      = m_axi_wstrb;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          addr_d      = req_addr & ADDR_MASK;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          if (req_wr) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          state_d      = S_RESP;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_wr_d    = 1'b1;
          resp_rdata_d = 32'd0;
          resp_code_d  = m_axi_bresp;
        end
      end
      S_RADDR: begin
        if (m_axi_arready) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          state_d      = S_RESP;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_wr_d    = 1'b0;
          resp_rdata_d = m_axi_rdata;
          resp_code_d  = m_axi_rresp;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge mips_cpu_clk) begin
    if (mips_cpu_reset) begin
      state_q       <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_wr       <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_code     <= 2'd0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      addr_q        <= '0;
      m_axi_wdata   <= 32'd0;
      m_axi_wstrb   <= 4'd0;
    end else begin
      state_q       <= state_d;
      req_ready     <= req_ready_d;
      resp_valid    <= resp_valid_d;
      resp_wr       <= resp_wr_d;
      resp_rdata    <= resp_rdata_d;
      resp_code     <= resp_code_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      addr_q        <= addr_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_axi_lite_master.sv
// Directed bench for mips_cpu_axi_lite_master: the slave side is driven by hand,
// cycle by cycle, and every observed output is compared to a hand-derived value.
module tb_mips_cpu_axi_lite_master;

  localparam int unsigned ADDR_WIDTH = 14;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid, req_ready, req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid, resp_ready, resp_wr;
  logic [31:0]           resp_rdata;
  logic [1:0]            resp_code;
  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic                  awvalid, awready, wvalid, wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic [1:0]            bresp, rresp;
  logic                  bvalid, bready, arvalid, arready;
  logic [31:0]           rdata;
  logic                  rvalid, rready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_cpu_axi_lite_master #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .mips_cpu_clk   (clk),
    .mips_cpu_reset (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wstrb      (req_wstrb),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_code      (resp_code),
    .resp_wr        (resp_wr),
    .m_axi_awaddr   (awaddr),
    .m_axi_awvalid  (awvalid),
    .m_axi_awready  (awready),
    .m_axi_wdata    (wdata),
    .m_axi_wstrb    (wstrb),
    .m_axi_wvalid   (wvalid),
    .m_axi_wready   (wready),
    .m_axi_bresp    (bresp),
    .m_axi_bvalid   (bvalid),
    .m_axi_bready   (bready),
    .m_axi_araddr   (araddr),
    .m_axi_arvalid  (arvalid),
    .m_axi_arready  (arready),
    .m_axi_rdata    (rdata),
    .m_axi_rresp    (rresp),
    .m_axi_rvalid   (rvalid),
    .m_axi_rready   (rready)
  );

  // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [ADDR_WIDTH-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);

    // Zero-wait write 0x1234 -> 0x0010
    awready = 1'b1; wready = 1'b1;
    issue(1'b1, 14'h0010, 32'h0000_1234, 4'hF);
    tick();
    req_valid = 1'b0;
    chk("w1_aw_w_valid", 32'({awvalid, wvalid}), 32'h3);
    chk("w1_awaddr", 32'(awaddr), 32'h10);
    chk("w1_wdata", wdata, 32'h0000_1234);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    chk("w1_req_ready", 32'(req_ready), 32'd0);
    chk("w1_bready_early", 32'(bready), 32'd0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    chk("w1_valids_drop", 32'({awvalid, wvalid}), 32'd0);
    chk("w1_bready", 32'(bready), 32'd1);
    chk("w1_no_resp_yet", 32'(resp_valid), 32'd0);
    tick();
    bvalid = 1'b0;
    chk("w1_resp_valid", 32'(resp_valid), 32'd1);
    chk("w1_resp_code", 32'(resp_code), 32'd0);
    chk("w1_resp_wr", 32'(resp_wr), 32'd1);
    chk("w1_resp_rdata", resp_rdata, 32'd0);
    chk("w1_bready_off", 32'(bready), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("w1_resp_done", 32'(resp_valid), 32'd0);
    chk("w1_req_ready_back", 32'(req_ready), 32'd1);

    // Read 0x0010, then hold resp_ready low with the next request already waiting
    arready = 1'b1;
    issue(1'b0, 14'h0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("r1_arvalid", 32'(arvalid), 32'd1);
    chk("r1_araddr", 32'(araddr), 32'h10);
    chk("r1_rready_early", 32'(rready), 32'd0);
    chk("r1_no_awvalid", 32'(awvalid), 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_1234; rresp = 2'b00;
    tick();
    chk("r1_arvalid_drop", 32'(arvalid), 32'd0);
    chk("r1_rready", 32'(rready), 32'd1);
    tick();
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
    chk("r1_resp_valid", 32'(resp_valid), 32'd1);
    chk("r1_resp_rdata", resp_rdata, 32'h0000_1234);
    chk("r1_resp_code", 32'(resp_code), 32'd0);
    chk("r1_resp_wr", 32'(resp_wr), 32'd0);
    issue(1'b0, 14'h0013, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, 32'h0000_1234);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_no_ar", 32'(arvalid), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("stall_resp_done", 32'(resp_valid), 32'd0);
    chk("stall_req_ready_back", 32'(req_ready), 32'd1);

    // Unaligned read 0x0013 returning SLVERR, accepted the cycle after the handshake
    tick();
    req_valid = 1'b0;
    chk("r2_arvalid", 32'(arvalid), 32'd1);
    chk("r2_araddr_aligned", 32'(araddr), 32'h10);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    tick();
    chk("r2_rready", 32'(rready), 32'd1);
    tick();
    rvalid = 1'b0;
    chk("r2_resp_valid", 32'(resp_valid), 32'd1);
    chk("r2_resp_code", 32'(resp_code), 32'h2);
    chk("r2_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Write with AW held off for three cycles, W immediate, DECERR on B
    awready = 1'b0; wready = 1'b1;
    issue(1'b1, 14'h0020, 32'hA5A5_5A5A, 4'h3);
    tick();
    req_valid = 1'b0;
    chk("w2_c1_valids", 32'({awvalid, wvalid}), 32'h3);
    tick();
    chk("w2_c2_wvalid_drop", 32'(wvalid), 32'd0);
    chk("w2_c2_awvalid", 32'(awvalid), 32'd1);
    chk("w2_c2_awaddr", 32'(awaddr), 32'h20);
    chk("w2_c2_bready", 32'(bready), 32'd0);
    tick();
    chk("w2_c3_awvalid", 32'(awvalid), 32'd1);
    chk("w2_c3_awaddr", 32'(awaddr), 32'h20);
    chk("w2_c3_bready", 32'(bready), 32'd0);
    tick();
    chk("w2_c4_awvalid", 32'(awvalid), 32'd1);
    chk("w2_c4_bready", 32'(bready), 32'd0);
    awready = 1'b1;
    tick();
    chk("w2_c5_awvalid_drop", 32'(awvalid), 32'd0);
    chk("w2_c5_bready", 32'(bready), 32'd1);
    chk("w2_c5_wdata", wdata, 32'hA5A5_5A5A);
    chk("w2_c5_wstrb", 32'(wstrb), 32'h3);
    tick();
    chk("w2_bstall_bready", 32'(bready), 32'd1);
    chk("w2_bstall_no_resp", 32'(resp_valid), 32'd0);
    bvalid = 1'b1; bresp = 2'b11;
    tick();
    bvalid = 1'b0;
    chk("w2_resp_valid", 32'(resp_valid), 32'd1);
    chk("w2_resp_code", 32'(resp_code), 32'h3);
    chk("w2_resp_rdata_cleared", resp_rdata, 32'd0);
    chk("w2_resp_wr", 32'(resp_wr), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset while AW/W are pending, then a clean read
    awready = 1'b0; wready = 1'b0;
    issue(1'b1, 14'h0030, 32'h1111_2222, 4'hF);
    tick();
    req_valid = 1'b0;
    chk("rs_awvalid_before", 32'(awvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_valids_cleared", 32'({awvalid, wvalid, arvalid, bready, rready, resp_valid}), 32'd0);
    chk("rs_req_ready", 32'(req_ready), 32'd1);
    chk("rs_awaddr_cleared", 32'(awaddr), 32'd0);
    chk("rs_wdata_cleared", wdata, 32'd0);
    arready = 1'b1;
    issue(1'b0, 14'h0040, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("rs_r_arvalid", 32'(arvalid), 32'd1);
    chk("rs_r_araddr", 32'(araddr), 32'h40);
    rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'b00;
    tick();
    tick();
    rvalid = 1'b0;
    chk("rs_r_resp_valid", 32'(resp_valid), 32'd1);
    chk("rs_r_rdata", resp_rdata, 32'h0BAD_F00D);
    chk("rs_r_code", 32'(resp_code), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("rs_r_req_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
